// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier core between
// NUM_REQ clients: accepts an operand pair, starts the core, returns the tagged product.
module booth_mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_m,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  output logic                         core_start,
  output logic [WIDTH-1:0]             core_m,
  output logic [WIDTH-1:0]             core_a,
  input  logic                         core_done,
  input  logic [2*WIDTH-1:0]           core_product,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]           rsp_product,
  output logic                         rsp_timeout,
  output logic                         busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [TMR_W-1:0]   timer;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH-1:0]   grant_m;
  logic [WIDTH-1:0]   grant_a;
  int unsigned        cand;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Operand slice of the granted requester.
  always_comb begin
    grant_m = '0;
    grant_a = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_m = req_m[i*WIDTH +: WIDTH];
        grant_a = req_a[i*WIDTH +: WIDTH];
      end
    end
  end

  // Accept is offered only while idle, so no request can slip in during RESP.
  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      timer       <= '0;
      core_start  <= 1'b0;
      core_m      <= '0;
      core_a      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            core_m     <= grant_m;
            core_a     <= grant_a;
            cur_id     <= grant_idx;
            rr_ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done on the expiry cycle still delivers the real product.
          if (core_done) begin
            rsp_product <= core_product;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            rsp_product <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural 3-cycle core, grant/response scoreboard,
// directed scenarios for ordering, fairness, backpressure, watchdog and reset.
module tb_booth_mult_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH-1:0]   req_m;
  logic [NUM_REQ*WIDTH-1:0]   req_a;
  logic                       core_start;
  logic [WIDTH-1:0]           core_m;
  logic [WIDTH-1:0]           core_a;
  logic                       core_done;
  logic [2*WIDTH-1:0]         core_product;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [1:0]                 rsp_id;
  logic [2*WIDTH-1:0]         rsp_product;
  logic                       rsp_timeout;
  logic                       busy;

  booth_mult_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_a(req_a),
    .core_start(core_start), .core_m(core_m), .core_a(core_a),
    .core_done(core_done), .core_product(core_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] m_val[4];
  logic [3:0] a_val[4];
  logic       model_on;
  logic       inject_done;
  int         cnt;
  int         exp_rr;
  logic [3:0] pend_m, pend_a;
  logic       prev_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_m[i*4 +: 4] = m_val[i];
      req_a[i*4 +: 4] = a_val[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] smul(input logic [3:0] m, input logic [3:0] a);
    logic signed [7:0] p;
    p = $signed({{4{m[3]}}, m}) * $signed({{4{a[3]}}, a});
    return 8'(p);
  endfunction

  // Core model: done three cycles after start unless disabled; one-shot injection.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (inject_done) begin
      core_done   = 1'b1;
      inject_done = 1'b0;
    end else if (core_start) begin
      if (model_on) cnt = 3;
      core_product = smul(core_m, core_a);
    end else if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) core_done = 1'b1;
    end
  end

  // Grant and response monitor feeding the scoreboard.
  always @(negedge clk) begin : mon
    int   g, e, c;
    exp_t x;
    if (!reset) begin
      if ((req_valid & req_ready) != 0) begin
        g = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        check("ready_onehot", 32'($countones(req_ready)), 1);
        e = -1;
        for (int k = 0; k < 4; k++) begin
          c = (exp_rr + k) % 4;
          if (e < 0 && req_valid[c]) e = c;
        end
        check("grant_id", g, e);
        grant_log.push_back(g);
        pend_m = m_val[g];
        pend_a = a_val[g];
        x.id = 2'(g);
        if (model_on) begin
          x.prod = smul(m_val[g], a_val[g]);
          x.to   = 1'b0;
        end else begin
          x.prod = 8'h00;
          x.to   = 1'b1;
        end
        sb.push_back(x);
        exp_rr = (e + 1) % 4;
      end
      if (core_start) begin
        check("core_m", core_m, pend_m);
        check("core_a", core_a, pend_a);
        check("start_single", prev_start, 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          x = sb.pop_front();
          check("rsp_id", rsp_id, x.id);
          check("rsp_product", rsp_product, x.prod);
          check("rsp_timeout", rsp_timeout, x.to);
        end
      end
    end
    prev_start = core_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int b = 0;
    while (!rsp_valid && b < 60) begin tick(); b++; end
    check("wait_rsp", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((busy || rsp_valid) && b < 60) begin tick(); b++; end
    check("wait_idle", busy | rsp_valid, 0);
  endtask

  task automatic wait_grants(input int n);
    int b = 0;
    while (grant_log.size() < n && b < 120) begin tick(); b++; end
    check("wait_grants", grant_log.size() >= n, 1);
  endtask

  task automatic wait_start();
    int b = 0;
    while (!core_start && b < 20) begin tick(); b++; end
    check("wait_start", core_start, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rr = 0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_m"}, core_m, 0);
    check({tag, "_core_a"}, core_a, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_product"}, rsp_product, 0);
    check({tag, "_rsp_timeout"}, rsp_timeout, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   k;
    int   exp2[5];
    int   exp3[4];
    logic [1:0] h_id;
    logic [7:0] h_prod;
    logic       h_to;

    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; model_on = 1'b1; inject_done = 1'b0;
    cnt = 0; exp_rr = 0; core_done = 1'b0; core_product = '0; prev_start = 1'b0;
    pend_m = '0; pend_a = '0;
    for (int i = 0; i < 4; i++) begin m_val[i] = '0; a_val[i] = '0; end
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Single request from requester 2.
    m_val[2] = 4'h3; a_val[2] = 4'hE; req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0100);
    tick();
    check("t1_ready_issue", req_ready, 0);
    check("t1_start", core_start, 1);
    check("t1_core_m", core_m, 4'h3);
    check("t1_core_a", core_a, 4'hE);
    check("t1_busy", busy, 1);
    req_valid = '0;
    tick();
    check("t1_start_once", core_start, 0);
    wait_rsp();
    check("t1_id", rsp_id, 2);
    check("t1_prod", rsp_product, 8'hFA);
    check("t1_to", rsp_timeout, 0);
    wait_idle();

    // All four requesters held valid from reset.
    pulse_reset();
    grant_log.delete();
    m_val[0] = 4'h7; a_val[0] = 4'h7;
    m_val[1] = 4'h8; a_val[1] = 4'h8;
    m_val[2] = 4'h3; a_val[2] = 4'hE;
    m_val[3] = 4'h5; a_val[3] = 4'hD;
    req_valid = 4'hF;
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    exp2 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      if (grant_log.size() > i) check("t2_order", grant_log[i], exp2[i]);
    check("t2_prod77", smul(m_val[0], a_val[0]), 8'h31);
    check("t2_prod88", smul(m_val[1], a_val[1]), 8'h40);

    // Fairness between requesters 0 and 3.
    pulse_reset();
    grant_log.delete();
    m_val[0] = 4'h2; a_val[0] = 4'h3;
    m_val[3] = 4'hF; a_val[3] = 4'h9;
    req_valid = 4'b1001;
    wait_grants(4);
    req_valid = '0;
    wait_idle();
    exp3 = '{0, 3, 0, 3};
    for (int i = 0; i < 4; i++)
      if (grant_log.size() > i) check("t3_order", grant_log[i], exp3[i]);

    // Response backpressure with another request pending.
    grant_log.delete();
    rsp_ready = 1'b0;
    m_val[1] = 4'h6; a_val[1] = 4'h5;
    m_val[0] = 4'hA; a_val[0] = 4'h3;
    req_valid = 4'b0010;
    wait_grants(1);
    req_valid = 4'b0001;
    wait_rsp();
    h_id = rsp_id; h_prod = rsp_product; h_to = rsp_timeout;
    check("t4_id", h_id, 1);
    check("t4_prod", h_prod, 8'h1E);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_valid_hold", rsp_valid, 1);
      check("t4_id_hold", rsp_id, h_id);
      check("t4_prod_hold", rsp_product, h_prod);
      check("t4_to_hold", rsp_timeout, h_to);
      check("t4_no_ready", req_ready, 0);
      check("t4_no_start", core_start, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_no_ready_last", req_ready, 0);
    @(negedge clk);
    check("t4_valid_drop", rsp_valid, 0);
    check("t4_next_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_idle();

    // Watchdog: core never answers, then a stray done arrives.
    model_on = 1'b0;
    m_val[3] = 4'h2; a_val[3] = 4'h2;
    req_valid = 4'b1000;
    wait_start();
    req_valid = '0;
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    check("t5_wait_cycles", k, 9);
    check("t5_to", rsp_timeout, 1);
    check("t5_prod", rsp_product, 0);
    check("t5_id", rsp_id, 3);
    tick(); tick();
    inject_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_late_valid", rsp_valid, 0);
      check("t5_late_busy", busy, 0);
    end
    model_on = 1'b1;

    // Reset while waiting on the core.
    m_val[2] = 4'h1; a_val[2] = 4'h1;
    req_valid = 4'b0100;
    wait_start();
    req_valid = '0;
    tick();
    reset = 1'b1;
    #1;
    check_zero("t6");
    tick();
    reset = 1'b0;
    sb.delete();
    exp_rr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_late_valid", rsp_valid, 0);
      check("t6_late_busy", busy, 0);
    end
    grant_log.delete();
    m_val[1] = 4'h4; a_val[1] = 4'hC;
    m_val[3] = 4'h7; a_val[3] = 4'h8;
    req_valid = 4'b1010;
    wait_grants(1);
    if (grant_log.size() > 0) check("t6_first", grant_log[0], 1);
    req_valid = 4'b1000;
    wait_grants(2);
    req_valid = '0;
    wait_idle();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
